// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// feeds IF/ID with a stall handshake and squashes wrong-path words on redirect.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [5:0]  HLT_OPCODE = 6'h3F,
    parameter logic [31:0] NOP_WORD   = 32'h0
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halted_in,
    output logic        if_id_valid,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_npc,
    output logic [31:0] pc_out,
    output logic        fetch_halted
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_HLT_WAIT,
        S_STOPPED
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_npc_q, req_npc_d;
    logic              imem_req_q, imem_req_d;
    logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0]   if_id_ir_q, if_id_ir_d;
    logic [XLEN-1:0]   if_id_npc_q, if_id_npc_d;
    logic              fetch_halted_q, fetch_halted_d;
    logic              hold_valid_q, hold_valid_d;
    logic [XLEN-1:0]   hold_ir_q, hold_ir_d;
    logic [XLEN-1:0]   hold_npc_q, hold_npc_d;
    logic              kill_q, kill_d;

    logic              free_c;
    logic              outstanding_c;
    logic              rdata_hlt_c;
    logic              hold_hlt_c;

    // IF/ID can take a word when empty or being consumed this cycle
    always_comb begin
        free_c        = !if_id_valid_q || !id_stall;
        // A request issued in FETCH is sampled by memory at this edge, so it counts as in flight
        outstanding_c = (state_q == S_WAIT) || ((state_q == S_FETCH) && imem_req_q);
        rdata_hlt_c   = (imem_rdata[XLEN-1 -: OPW] == HLT_OPCODE);
        hold_hlt_c    = (hold_ir_q[XLEN-1 -: OPW] == HLT_OPCODE);
    end

    // Next-state and next-output computation
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_npc_d      = req_npc_q;
        if_id_valid_d  = if_id_valid_q;
        if_id_ir_d     = if_id_ir_q;
        if_id_npc_d    = if_id_npc_q;
        hold_valid_d   = hold_valid_q;
        hold_ir_d      = hold_ir_q;
        hold_npc_d     = hold_npc_q;
        kill_d         = kill_q;
        imem_req_d     = 1'b0;
        imem_addr_d    = imem_addr_q;
        fetch_halted_d = fetch_halted_q;

        if (if_id_valid_q && !id_stall) begin
            if_id_valid_d = 1'b0;
        end

        unique case (state_q)
            S_FETCH: begin
                // Out of reset the first request has not been driven yet; stay until it has
                if (imem_req_q) begin
                    req_npc_d = pc_q + XLEN'(1);
                    pc_d      = pc_q + XLEN'(1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else if (free_c) begin
                        if_id_valid_d = 1'b1;
                        if_id_ir_d    = imem_rdata;
                        if_id_npc_d   = req_npc_q;
                        state_d       = rdata_hlt_c ? S_HLT_WAIT : S_FETCH;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_ir_d    = imem_rdata;
                        hold_npc_d   = req_npc_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (free_c && hold_valid_q) begin
                    if_id_valid_d = 1'b1;
                    if_id_ir_d    = hold_ir_q;
                    if_id_npc_d   = hold_npc_q;
                    hold_valid_d  = 1'b0;
                    state_d       = hold_hlt_c ? S_HLT_WAIT : S_FETCH;
                end
            end
            S_HLT_WAIT: begin
                state_d = S_HLT_WAIT;
            end
            S_STOPPED: begin
                state_d = S_STOPPED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Retired HLT wins over everything; a redirect squashes all wrong-path state
        if (halted_in) begin
            state_d       = S_STOPPED;
            if_id_valid_d = 1'b0;
        end else if (br_taken && (state_q != S_STOPPED)) begin
            pc_d          = br_target;
            if_id_valid_d = 1'b0;
            if_id_ir_d    = NOP_WORD;
            hold_valid_d  = 1'b0;
            if (outstanding_c && !((state_q == S_WAIT) && imem_valid)) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_FETCH;
            end
        end

        // Request is registered so it is visible for exactly the FETCH cycle
        if (state_d == S_FETCH) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_d;
        end

        fetch_halted_d = (state_d == S_HLT_WAIT) || (state_d == S_STOPPED);
    end

    // State and output registers
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            req_npc_q      <= '0;
            imem_req_q     <= 1'b0;
            imem_addr_q    <= RESET_PC;
            if_id_valid_q  <= 1'b0;
            if_id_ir_q     <= NOP_WORD;
            if_id_npc_q    <= '0;
            fetch_halted_q <= 1'b0;
            hold_valid_q   <= 1'b0;
            hold_ir_q      <= '0;
            hold_npc_q     <= '0;
            kill_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_npc_q      <= req_npc_d;
            imem_req_q     <= imem_req_d;
            imem_addr_q    <= imem_addr_d;
            if_id_valid_q  <= if_id_valid_d;
            if_id_ir_q     <= if_id_ir_d;
            if_id_npc_q    <= if_id_npc_d;
            fetch_halted_q <= fetch_halted_d;
            hold_valid_q   <= hold_valid_d;
            hold_ir_q      <= hold_ir_d;
            hold_npc_q     <= hold_npc_d;
            kill_q         <= kill_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = imem_addr_q;
    assign if_id_valid  = if_id_valid_q;
    assign if_id_ir     = if_id_ir_q;
    assign if_id_npc    = if_id_npc_q;
    assign pc_out       = pc_q;
    assign fetch_halted = fetch_halted_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios plus a randomized run checked
// against an in-order program-stream model with a latency-programmable memory.
module tb_mips_fetch_stage;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halted_in;
    logic        if_id_valid;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    logic [31:0] pc_out;
    logic        fetch_halted;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:63];
    int          mem_lat = 1;
    bit          mem_rand_lat = 1'b0;
    int          cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t       pend_q[$];
    logic [31:0] req_log[$];
    logic [31:0] got_ir[$];
    logic [31:0] got_npc[$];

    mips_fetch_stage dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halted_in   (halted_in),
        .if_id_valid (if_id_valid),
        .if_id_ir    (if_id_ir),
        .if_id_npc   (if_id_npc),
        .pc_out      (pc_out),
        .fetch_halted(fetch_halted)
    );

    always #5 clk1 = ~clk1;

    // Memory model: a request seen in cycle n is answered during cycle n+latency
    always @(negedge clk1) begin
        pend_t       p;
        logic [31:0] a;
        cyc = cyc + 1;
        imem_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            a = pend_q[0].addr;
            imem_valid = 1'b1;
            imem_rdata = mem[a[5:0]];
            void'(pend_q.pop_front());
        end
        if (imem_req === 1'b1) begin
            p.due  = cyc + (mem_rand_lat ? int'($urandom_range(3, 1)) : mem_lat);
            p.addr = imem_addr;
            pend_q.push_back(p);
            req_log.push_back(imem_addr);
        end
    end

    task automatic step();
        @(posedge clk1);
        #2;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        id_stall  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        halted_in = 1'b0;
        repeat (6) step();
        rst_n = 1'b1;
    endtask

    // Record every word decode takes (valid, not stalled, not flushed) until n seen
    task automatic collect(input int n, input int budget);
        got_ir.delete();
        got_npc.delete();
        for (int c = 0; c < budget && got_ir.size() < n; c++) begin
            if (if_id_valid === 1'b1 && id_stall == 1'b0 && br_taken == 1'b0) begin
                got_ir.push_back(if_id_ir);
                got_npc.push_back(if_id_npc);
            end
            step();
        end
    endtask

    task automatic test_reset();
        fill_mem();
        mem_lat = 1;
        mem_rand_lat = 1'b0;
        rst_n = 1'b0; id_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; halted_in = 1'b0;
        repeat (3) step();
        vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        vectors++; if (if_id_ir !== 32'h0) begin miscompares++; $display("FAIL reset_ir: got %h expected %h", if_id_ir, 32'h0); end
        vectors++; if (if_id_npc !== 32'h0) begin miscompares++; $display("FAIL reset_npc: got %h expected %h", if_id_npc, 32'h0); end
        vectors++; if (fetch_halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", fetch_halted); end
    endtask

    task automatic test_straight();
        logic [31:0] exp_ir [3];
        fill_mem();
        mem[0] = 32'h2801_0000; mem[1] = 32'h0000_0000; mem[2] = 32'hFC00_0000;
        exp_ir = '{32'h2801_0000, 32'h0000_0000, 32'hFC00_0000};
        mem_lat = 1;
        apply_reset();
        collect(3, 40);
        vectors++; if (got_ir.size() != 3) begin miscompares++; $display("FAIL straight_count: got %0d expected 3", got_ir.size()); end
        for (int i = 0; i < got_ir.size() && i < 3; i++) begin
            vectors++; if (got_ir[i] !== exp_ir[i]) begin miscompares++; $display("FAIL straight_ir%0d: got %h expected %h", i, got_ir[i], exp_ir[i]); end
            vectors++; if (got_npc[i] !== 32'(i + 1)) begin miscompares++; $display("FAIL straight_npc%0d: got %h expected %h", i, got_npc[i], 32'(i + 1)); end
        end
        vectors++; if (fetch_halted !== 1'b1) begin miscompares++; $display("FAIL straight_halted: got %b expected 1", fetch_halted); end
        req_log.delete();
        repeat (20) step();
        vectors++; if (req_log.size() != 0) begin miscompares++; $display("FAIL straight_no_req: got %0d requests expected 0", req_log.size()); end
        vectors++; if (fetch_halted !== 1'b1) begin miscompares++; $display("FAIL straight_halted_hold: got %b expected 1", fetch_halted); end
    endtask

    task automatic test_stall();
        fill_mem();
        mem[0] = 32'h2001_0001; mem[1] = 32'h2002_0002; mem[2] = 32'h2003_0003;
        mem_lat = 1;
        apply_reset();
        for (int c = 0; c < 20 && if_id_valid !== 1'b1; c++) step();
        vectors++; if (if_id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_first_load: got %b expected 1", if_id_valid); end
        req_log.delete();
        id_stall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            vectors++; if (if_id_valid !== 1'b1 || if_id_npc !== 32'h1) begin miscompares++; $display("FAIL stall_hold%0d: got valid %b npc %h expected 1 00000001", c, if_id_valid, if_id_npc); end
            step();
        end
        vectors++; if (req_log.size() != 1) begin miscompares++; $display("FAIL stall_req_count: got %0d expected 1", req_log.size()); end
        if (req_log.size() > 0) begin
            vectors++; if (req_log[0] !== 32'h1) begin miscompares++; $display("FAIL stall_req_addr: got %h expected %h", req_log[0], 32'h1); end
        end
        id_stall = 1'b0;
        collect(3, 40);
        vectors++; if (got_ir.size() != 3) begin miscompares++; $display("FAIL stall_count: got %0d expected 3", got_ir.size()); end
        for (int i = 0; i < got_ir.size() && i < 3; i++) begin
            vectors++; if (got_npc[i] !== 32'(i + 1) || got_ir[i] !== mem[i]) begin miscompares++; $display("FAIL stall_order%0d: got %h/%h expected %h/%h", i, got_ir[i], got_npc[i], mem[i], 32'(i + 1)); end
        end
    endtask

    task automatic test_kill();
        int found;
        fill_mem();
        mem[5]  = 32'hDEAD_0005;
        mem[14] = 32'h2804_0063;
        mem_lat = 3;
        apply_reset();
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (imem_req === 1'b1 && imem_addr === 32'd5) found = 1;
            else step();
        end
        vectors++; if (found != 1) begin miscompares++; $display("FAIL kill_req5: got %0d expected 1", found); end
        step();
        br_taken = 1'b1; br_target = 32'd14;
        step();
        br_taken = 1'b0;
        vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL kill_flush: got %b expected 0", if_id_valid); end
        for (int c = 0; c < 20 && imem_req !== 1'b1; c++) step();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'd14) begin miscompares++; $display("FAIL kill_redirect: got req %b addr %h expected 1 %h", imem_req, imem_addr, 32'd14); end
        collect(1, 30);
        vectors++; if (got_ir.size() != 1) begin miscompares++; $display("FAIL kill_count: got %0d expected 1", got_ir.size()); end
        if (got_ir.size() > 0) begin
            vectors++; if (got_ir[0] !== 32'h2804_0063 || got_npc[0] !== 32'd15) begin miscompares++; $display("FAIL kill_word: got %h/%h expected %h/%h", got_ir[0], got_npc[0], 32'h2804_0063, 32'd15); end
        end
    endtask

    task automatic test_collision();
        int found;
        fill_mem();
        mem[9] = 32'h2009_0009;
        mem_lat = 1;
        apply_reset();
        id_stall = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (imem_req === 1'b1 && imem_addr === 32'd1) found = 1;
            else step();
        end
        vectors++; if (found != 1) begin miscompares++; $display("FAIL coll_req1: got %0d expected 1", found); end
        step();
        br_taken = 1'b1; br_target = 32'd9;
        step();
        br_taken = 1'b0;
        vectors++; if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL coll_flush: got %b expected 0", if_id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'd9) begin miscompares++; $display("FAIL coll_redirect: got req %b addr %h expected 1 %h", imem_req, imem_addr, 32'd9); end
        id_stall = 1'b0;
        collect(1, 20);
        vectors++; if (got_ir.size() != 1) begin miscompares++; $display("FAIL coll_count: got %0d expected 1", got_ir.size()); end
        if (got_ir.size() > 0) begin
            vectors++; if (got_ir[0] !== 32'h2009_0009 || got_npc[0] !== 32'd10) begin miscompares++; $display("FAIL coll_word: got %h/%h expected %h/%h", got_ir[0], got_npc[0], 32'h2009_0009, 32'd10); end
        end
    endtask

    task automatic test_spec_hlt();
        fill_mem();
        mem[6]  = 32'hFC00_0000;
        mem[14] = 32'h2804_0063;
        mem_lat = 1;
        apply_reset();
        for (int c = 0; c < 60 && fetch_halted !== 1'b1; c++) step();
        vectors++; if (fetch_halted !== 1'b1) begin miscompares++; $display("FAIL hlt_wait: got %b expected 1", fetch_halted); end
        req_log.delete();
        repeat (5) step();
        vectors++; if (req_log.size() != 0) begin miscompares++; $display("FAIL hlt_no_req: got %0d expected 0", req_log.size()); end
        br_taken = 1'b1; br_target = 32'd14;
        step();
        br_taken = 1'b0;
        vectors++; if (fetch_halted !== 1'b0) begin miscompares++; $display("FAIL hlt_resume: got %b expected 0", fetch_halted); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'd14) begin miscompares++; $display("FAIL hlt_redirect: got req %b addr %h expected 1 %h", imem_req, imem_addr, 32'd14); end
        collect(1, 20);
        vectors++; if (got_ir.size() != 1 || got_npc[0] !== 32'd15) begin miscompares++; $display("FAIL hlt_word: got %0d words npc %h expected 1 %h", got_ir.size(), (got_npc.size() > 0) ? got_npc[0] : 32'hX, 32'd15); end
        halted_in = 1'b1; br_taken = 1'b1; br_target = 32'd3;
        step();
        halted_in = 1'b0; br_taken = 1'b0;
        vectors++; if (fetch_halted !== 1'b1 || if_id_valid !== 1'b0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL stop_enter: got halted %b valid %b req %b expected 1 0 0", fetch_halted, if_id_valid, imem_req); end
        req_log.delete();
        br_taken = 1'b1; br_target = 32'd3;
        step();
        br_taken = 1'b0;
        repeat (10) step();
        vectors++; if (req_log.size() != 0) begin miscompares++; $display("FAIL stop_no_req: got %0d expected 0", req_log.size()); end
        vectors++; if (fetch_halted !== 1'b1 || pc_out === 32'd3) begin miscompares++; $display("FAIL stop_ignore_br: got halted %b pc %h expected 1 and pc not 3", fetch_halted, pc_out); end
    endtask

    task automatic test_reset_mid_wait();
        fill_mem();
        mem_lat = 4;
        apply_reset();
        for (int c = 0; c < 10 && imem_req !== 1'b1; c++) step();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rmw_first_req: got req %b addr %h expected 1 0", imem_req, imem_addr); end
        step();
        rst_n = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || pc_out !== 32'h0 || imem_addr !== 32'h0 || fetch_halted !== 1'b0 || if_id_ir !== 32'h0 || if_id_npc !== 32'h0) begin
            miscompares++; $display("FAIL rmw_async: got req %b valid %b pc %h addr %h halted %b ir %h npc %h expected all reset values", imem_req, if_id_valid, pc_out, imem_addr, fetch_halted, if_id_ir, if_id_npc);
        end
        step();
        step();
        rst_n = 1'b1;
        req_log.delete();
        collect(2, 40);
        vectors++; if (req_log.size() == 0 || req_log[0] !== 32'h0) begin miscompares++; $display("FAIL rmw_restart_addr: got %0d requests first %h expected addr 0", req_log.size(), (req_log.size() > 0) ? req_log[0] : 32'hX); end
        vectors++; if (got_ir.size() != 2) begin miscompares++; $display("FAIL rmw_count: got %0d expected 2", got_ir.size()); end
        for (int i = 0; i < got_ir.size() && i < 2; i++) begin
            vectors++; if (got_npc[i] !== 32'(i + 1) || got_ir[i] !== mem[i]) begin miscompares++; $display("FAIL rmw_word%0d: got %h/%h expected %h/%h", i, got_ir[i], got_npc[i], mem[i], 32'(i + 1)); end
        end
    endtask

    // Program-order model: decode must see mem[a], mem[a+1], ... restarting at each branch target
    task automatic test_random();
        logic [31:0] w;
        logic [31:0] exp_addr;
        int          consumed;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:26] == 6'h3F) w[31:26] = 6'h01;
            mem[i] = w;
        end
        mem_rand_lat = 1'b1;
        apply_reset();
        exp_addr = 32'h0;
        consumed = 0;
        for (int c = 0; c < 2000; c++) begin
            id_stall  = ($urandom_range(99) < 30);
            br_taken  = ($urandom_range(99) < 3);
            br_target = 32'($urandom_range(63));
            if (br_taken) begin
                exp_addr = br_target;
            end else if (if_id_valid === 1'b1 && !id_stall) begin
                vectors++;
                if (if_id_ir !== mem[exp_addr[5:0]] || if_id_npc !== exp_addr + 32'd1) begin
                    miscompares++;
                    $display("FAIL rand_word: got %h/%h expected %h/%h", if_id_ir, if_id_npc, mem[exp_addr[5:0]], exp_addr + 32'd1);
                end
                exp_addr = exp_addr + 32'd1;
                consumed++;
            end
            step();
        end
        br_taken = 1'b0;
        id_stall = 1'b0;
        mem_rand_lat = 1'b0;
        vectors++; if (consumed < 100) begin miscompares++; $display("FAIL rand_progress: got %0d consumed expected at least 100", consumed); end
    endtask

    initial begin
        rst_n = 1'b0; id_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; halted_in = 1'b0;
        test_reset();
        test_straight();
        test_stall();
        test_kill();
        test_collision();
        test_spec_hlt();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
